// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and parity helper for the UART transmit framer.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned MAX_DATA_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Word is zero-extended by the caller, so the padding never affects the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] word,
                                      input int unsigned           mode);
    return (^word) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Word-in / serial-out bundle between a producer (master) and the framer (slave).
interface uart_tx_framer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 3
) ();
  logic              br_stb;
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic              din_rdy;
  logic              txd;
  logic              busy;
  logic [CNT_W-1:0]  fifo_cnt;

  modport master (
    output br_stb, din, din_vld,
    input  din_rdy, txd, busy, fifo_cnt
  );

  modport slave (
    input  br_stb, din, din_vld,
    output din_rdy, txd, busy, fifo_cnt
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_wr_en = wr && !full;
  assign w_rd_en = rd && !empty;
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign cnt     = r_wr_ptr - r_rd_ptr;
  assign rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// Buffered UART transmitter: queues words and serialises start/data/parity/stop per baud strobe.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_framer_if.slave  bus
);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W     = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_framer: DATA_W must be within 5..9");
  end
  if (PARITY_MODE > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_framer: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_framer: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e          r_state;
  logic [DATA_W-1:0]  r_word;
  logic [DATA_W-1:0]  r_shift;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_stop_cnt;
  logic               r_txd;
  logic               r_busy;

  logic [DATA_W-1:0]  w_head;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_push;
  logic               w_pop;
  logic               w_frame_end;
  logic               w_parity;

  assign w_frame_end  = (r_state == ST_STOP) && (r_stop_cnt == STOP_LAST);
  assign w_pop        = bus.br_stb && !w_empty && ((r_state == ST_IDLE) || w_frame_end);
  assign w_push       = bus.din_vld && bus.din_rdy;
  assign w_parity     = parity_bit(MAX_DATA_W'(r_word), PARITY_MODE);

  assign bus.din_rdy  = !w_full && !rst;
  assign bus.txd      = r_txd;
  assign bus.busy     = r_busy;
  assign bus.fifo_cnt = w_cnt;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (w_push),
    .wdata (bus.din),
    .rd    (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .cnt   (w_cnt)
  );

  // Everything advances only on strobe edges; r_word stays intact for the parity bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_word     <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
    end else if (bus.br_stb) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_word  <= w_head;
            r_shift <= w_head;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_txd     <= r_shift[0];
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= '0;
          r_state   <= ST_DATA;
        end
        ST_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_stop_cnt <= 1'b0;
            if (PARITY_MODE != PARITY_NONE) begin
              r_txd   <= w_parity;
              r_state <= ST_PARITY;
            end else begin
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_txd     <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end
        end
        ST_PARITY: begin
          r_txd      <= 1'b1;
          r_stop_cnt <= 1'b0;
          r_state    <= ST_STOP;
        end
        ST_STOP: begin
          if (!w_frame_end) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end else if (!w_empty) begin
            r_word  <= w_head;
            r_shift <= w_head;
            r_txd   <= 1'b0;
            r_state <= ST_START;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
